// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster timing generator: HS/VS/video-enable, pixel coordinates and start pulses
module video_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_ve,
  output logic [1:0]    o_control,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Phase boundaries as counter values; a zero-length porch makes two equal,
  // so the decode below never lands in that phase.
  localparam logic [CW-1:0] H_END_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_END_FP   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_END_SYNC = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_END_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_END_FP   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_END_SYNC = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

  typedef enum logic [1:0] {ST_ACT, ST_FP, ST_SYNC, ST_BP} phase_t;

  logic [CW-1:0] h_cnt, h_cnt_nxt, v_cnt, v_cnt_nxt;
  phase_t        h_state, h_state_nxt, v_state, v_state_nxt;
  logic          h_wrap, v_wrap;
  logic          ve_c;

  function automatic phase_t phase_of(input logic [CW-1:0] c, input logic [CW-1:0] e_act,
                                      input logic [CW-1:0] e_fp, input logic [CW-1:0] e_sync);
    if (c < e_act)       return ST_ACT;
    else if (c < e_fp)   return ST_FP;
    else if (c < e_sync) return ST_SYNC;
    else                 return ST_BP;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_state <= ST_ACT;
      v_state <= ST_ACT;
    end else if (i_en) begin
      h_cnt   <= h_cnt_nxt;
      v_cnt   <= v_cnt_nxt;
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
    end
  end

  always_comb begin
    h_cnt_nxt   = h_cnt;
    v_cnt_nxt   = v_cnt;
    h_state_nxt = h_state;
    v_state_nxt = v_state;
    h_wrap      = (h_cnt == H_LAST);
    v_wrap      = (v_cnt == V_LAST);
    h_cnt_nxt   = h_wrap ? '0 : h_cnt + 1'b1;
    // Vertical machine only steps at the end of each line.
    if (h_wrap) v_cnt_nxt = v_wrap ? '0 : v_cnt + 1'b1;
    h_state_nxt = phase_of(h_cnt_nxt, H_END_ACT, H_END_FP, H_END_SYNC);
    v_state_nxt = phase_of(v_cnt_nxt, V_END_ACT, V_END_FP, V_END_SYNC);
  end

  assign ve_c = (h_state == ST_ACT) && (v_state == ST_ACT);

  // Outputs describe the counters as they stand now, i.e. one cycle behind.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ve          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_hs          <= ~HS_POL;
      o_vs          <= ~VS_POL;
      o_control     <= {~VS_POL, ~HS_POL};
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (i_en) begin
      o_ve          <= ve_c;
      o_x           <= ve_c ? h_cnt : '0;
      o_y           <= ve_c ? v_cnt : '0;
      o_hs          <= (h_state == ST_SYNC) ? HS_POL : ~HS_POL;
      o_vs          <= (v_state == ST_SYNC) ? VS_POL : ~VS_POL;
      o_control     <= {(v_state == ST_SYNC) ? VS_POL : ~VS_POL,
                        (h_state == ST_SYNC) ? HS_POL : ~HS_POL};
      o_line_start  <= ve_c && (h_cnt == '0);
      o_frame_start <= ve_c && (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule
